// File: rtl/flash_arbiter_pkg.sv
// flash_arbiter_pkg: shared widths and FSM state encoding for the flash arbiter
package flash_arbiter_pkg;
  localparam int ADDR_W = 24;
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_TERM, S_TW1, S_TW0, S_ISSUE, S_WB, S_WD} state_t;
endpackage

// File: rtl/flash_arbiter_if.sv
// flash_arbiter_if: requester and SPI byte-reader signals of the flash arbiter
// slave  : arbiter side (takes req/addr and reader status, drives ack/dout and reader controls)
// master : environment side (requesters plus reader)
interface flash_arbiter_if;
  import flash_arbiter_pkg::*;
  logic              req0, req1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic              ack0, ack1;
  logic [7:0]        dout;
  logic              stream_open;
  logic [ADDR_W-1:0] fl_addr;
  logic              fl_rd, fl_terminate;
  logic [7:0]        fl_dout;
  logic              fl_data_ready, fl_busy;
  modport slave (
    input  req0, req1, addr0, addr1, fl_dout, fl_data_ready, fl_busy,
    output ack0, ack1, dout, stream_open, fl_addr, fl_rd, fl_terminate
  );
  modport master (
    output req0, req1, addr0, addr1, fl_dout, fl_data_ready, fl_busy,
    input  ack0, ack1, dout, stream_open, fl_addr, fl_rd, fl_terminate
  );
endinterface

// File: rtl/flash_arbiter_rr_arb.sv
// flash_rr_arb: combinational 2-way round-robin grant
// req : active requests, ptr : preferred port on a tie, gnt : one-hot grant (0 when idle)
module flash_rr_arb (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);
  assign gnt = (req == 2'b11) ? (ptr ? 2'b10 : 2'b01) : req;
endmodule

// File: rtl/flash_arbiter.sv
// flash_arbiter: shares one SPI flash byte reader between two requesters, keeping sequential streams open
// clk, reset_n : clock and asynchronous active-low reset
// bus (slave)  : req/addr/ack/dout/stream_open to requesters, fl_* to the byte reader
// IDLE_CLOSE   : idle cycles with an open stream before auto-terminate (0 = never)
module flash_arbiter
  import flash_arbiter_pkg::*;
#(
  parameter int IDLE_CLOSE = 1024
) (
  input  logic           clk,
  input  logic           reset_n,
  flash_arbiter_if.slave bus
);
  state_t            state_q, state_d;
  logic [1:0]        ack_q, ack_d;
  logic [7:0]        dout_q, dout_d;
  logic              stream_open_q, stream_open_d;
  logic [ADDR_W-1:0] fl_addr_q, fl_addr_d;
  logic              fl_rd_q, fl_rd_d;
  logic              fl_term_q, fl_term_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              gid_q, gid_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [31:0]       idle_cnt_q, idle_cnt_d;
  logic [1:0]        req_v, gnt;
  logic [ADDR_W-1:0] req_addr;
  // the port being acked this cycle still holds req; masking it stops a duplicate grant
  assign req_v    = {bus.req1, bus.req0} & ~ack_q;
  assign req_addr = gnt[1] ? bus.addr1 : bus.addr0;
  flash_rr_arb u_arb (.req(req_v), .ptr(rr_ptr_q), .gnt(gnt));
  always_comb begin
    state_d       = state_q;
    ack_d         = 2'b00;
    dout_d        = dout_q;
    stream_open_d = stream_open_q;
    fl_addr_d     = fl_addr_q;
    fl_rd_d       = 1'b0;
    fl_term_d     = 1'b0;
    rr_ptr_d      = rr_ptr_q;
    gid_d         = gid_q;
    pend_d        = pend_q;
    next_addr_d   = next_addr_q;
    idle_cnt_d    = idle_cnt_q;
    case (state_q)
      S_INIT: state_d = bus.fl_busy ? S_INIT : S_IDLE;
      S_IDLE: begin
        if (|gnt && !bus.fl_busy) begin
          gid_d      = gnt[1];
          fl_addr_d  = req_addr;
          idle_cnt_d = '0;
          pend_d     = 1'b1;
          // an address jump must close the open stream before the new read command
          fl_term_d  = stream_open_q && (req_addr != next_addr_q);
          fl_rd_d    = !fl_term_d;
          state_d    = fl_term_d ? S_TERM : S_ISSUE;
        end else if (stream_open_q && !(|gnt)) begin
          if (IDLE_CLOSE != 0 && idle_cnt_q == 32'(IDLE_CLOSE - 1)) begin
            fl_term_d = 1'b1;
            pend_d    = 1'b0;
            state_d   = S_TERM;
          end else if (idle_cnt_q != '1)
            idle_cnt_d = idle_cnt_q + 32'd1;
        end
      end
      S_TERM: state_d = S_TW1;
      S_TW1:  state_d = bus.fl_busy ? S_TW0 : S_TW1;
      S_TW0: begin
        if (!bus.fl_busy) begin
          stream_open_d = 1'b0;
          fl_rd_d       = pend_q;
          state_d       = pend_q ? S_ISSUE : S_IDLE;
        end
      end
      S_ISSUE: state_d = S_WB;
      // waiting for busy first keeps a stale data_ready from the previous byte out
      S_WB:    state_d = bus.fl_busy ? S_WD : S_WB;
      S_WD: begin
        if (bus.fl_data_ready && !bus.fl_busy) begin
          dout_d        = bus.fl_dout;
          ack_d         = gid_q ? 2'b10 : 2'b01;
          stream_open_d = 1'b1;
          next_addr_d   = fl_addr_q + ADDR_W'(1);
          rr_ptr_d      = ~gid_q;
          pend_d        = 1'b0;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_INIT;
      ack_q         <= 2'b00;
      dout_q        <= '0;
      stream_open_q <= 1'b0;
      fl_addr_q     <= '0;
      fl_rd_q       <= 1'b0;
      fl_term_q     <= 1'b0;
      rr_ptr_q      <= 1'b0;
      gid_q         <= 1'b0;
      pend_q        <= 1'b0;
      next_addr_q   <= '0;
      idle_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      ack_q         <= ack_d;
      dout_q        <= dout_d;
      stream_open_q <= stream_open_d;
      fl_addr_q     <= fl_addr_d;
      fl_rd_q       <= fl_rd_d;
      fl_term_q     <= fl_term_d;
      rr_ptr_q      <= rr_ptr_d;
      gid_q         <= gid_d;
      pend_q        <= pend_d;
      next_addr_q   <= next_addr_d;
      idle_cnt_q    <= idle_cnt_d;
    end
  end
  assign bus.ack0         = ack_q[0];
  assign bus.ack1         = ack_q[1];
  assign bus.dout         = dout_q;
  assign bus.stream_open  = stream_open_q;
  assign bus.fl_addr      = fl_addr_q;
  assign bus.fl_rd        = fl_rd_q;
  assign bus.fl_terminate = fl_term_q;
endmodule
